// File: rtl/cg_rvarch_instr_encoder.sv
// rtl/cg_rvarch_instr_encoder.sv - streaming RV32 instruction encoder with LI expansion
module cg_rvarch_instr_encoder #(
  parameter int INSTR_WIDTH = 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [2:0]             i_fmt,
  input  logic [6:0]             i_opcode,
  input  logic [4:0]             i_rd,
  input  logic [4:0]             i_rs1,
  input  logic [4:0]             i_rs2,
  input  logic [2:0]             i_funct3,
  input  logic [6:0]             i_funct7,
  input  logic [31:0]            i_imm,
  output logic                   o_valid,
  input  logic                   i_ready,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic                   o_err,
  output logic                   o_last
);

  localparam logic [2:0] FMT_R  = 3'd0;
  localparam logic [2:0] FMT_I  = 3'd1;
  localparam logic [2:0] FMT_S  = 3'd2;
  localparam logic [2:0] FMT_B  = 3'd3;
  localparam logic [2:0] FMT_U  = 3'd4;
  localparam logic [2:0] FMT_J  = 3'd5;
  localparam logic [2:0] FMT_LI = 3'd6;

  localparam logic [6:0] OP_ADDI = 7'h13;
  localparam logic [6:0] OP_LUI  = 7'h37;

  typedef enum logic [1:0] {
    EMPTY     = 2'd0,
    FULL      = 2'd1,
    FULL_PEND = 2'd2
  } state_t;

  state_t state, state_nxt;

  logic [31:0] word_a;
  logic        err_a;
  logic        split;
  logic [31:0] word_b;
  logic [31:0] pend_instr;
  logic [31:0] li_sum;
  logic [19:0] li_hi;
  logic [11:0] li_lo;
  logic        opc_bad;
  logic        sext11_ok;
  logic        sext12_ok;
  logic        sext20_ok;
  logic        accept;
  logic        pend_move;

  assign o_valid   = (state != EMPTY);
  assign o_ready   = (state == EMPTY) || ((state == FULL) && i_ready);
  assign accept    = i_valid && o_ready;
  assign pend_move = (state == FULL_PEND) && i_ready;

  // LI splits as hi/lo with the +0x800 rounding so the sign-extended ADDI lands on V
  assign li_sum    = i_imm + 32'h0000_0800;
  assign li_hi     = li_sum[31:12];
  assign li_lo     = i_imm[11:0];

  // Immediate fits when all bits above the encodable range match the sign bit
  assign opc_bad   = (i_opcode[1:0] != 2'b11);
  assign sext11_ok = (&i_imm[31:11]) || !(|i_imm[31:11]);
  assign sext12_ok = (&i_imm[31:12]) || !(|i_imm[31:12]);
  assign sext20_ok = (&i_imm[31:20]) || !(|i_imm[31:20]);

  // Field packing and legality for the incoming request
  always_comb begin
    word_a = 32'h0;
    err_a  = 1'b0;
    split  = 1'b0;
    word_b = 32'h0;
    case (i_fmt)
      FMT_R: begin
        word_a = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
        err_a  = opc_bad;
      end
      FMT_I: begin
        word_a = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
        err_a  = opc_bad || !sext11_ok;
      end
      FMT_S: begin
        word_a = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
        err_a  = opc_bad || !sext11_ok;
      end
      FMT_B: begin
        word_a = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3, i_imm[4:1], i_imm[11], i_opcode};
        err_a  = opc_bad || !sext12_ok || i_imm[0];
      end
      FMT_U: begin
        word_a = {i_imm[31:12], i_rd, i_opcode};
        err_a  = opc_bad || (i_imm[11:0] != 12'h0);
      end
      FMT_J: begin
        word_a = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12], i_rd, i_opcode};
        err_a  = opc_bad || !sext20_ok || i_imm[0];
      end
      FMT_LI: begin
        if (li_hi == 20'h0) begin
          word_a = {li_lo, 5'd0, 3'b000, i_rd, OP_ADDI};
        end else if (li_lo == 12'h0) begin
          word_a = {li_hi, i_rd, OP_LUI};
        end else begin
          word_a = {li_hi, i_rd, OP_LUI};
          word_b = {li_lo, i_rd, 3'b000, i_rd, OP_ADDI};
          split  = 1'b1;
        end
      end
      default: begin
        word_a = 32'h0;
        err_a  = 1'b1;
      end
    endcase
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state: a pending ADDI always passes through FULL before the slot can empty
  always_comb begin
    state_nxt = state;
    case (state)
      EMPTY: begin
        if (accept) state_nxt = split ? FULL_PEND : FULL;
      end
      FULL: begin
        if (accept)       state_nxt = split ? FULL_PEND : FULL;
        else if (i_ready) state_nxt = EMPTY;
      end
      FULL_PEND: begin
        if (i_ready) state_nxt = FULL;
      end
      default: state_nxt = EMPTY;
    endcase
  end

  // Output word and pending ADDI registers; held unless a load is due
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_instr    <= '0;
      o_err      <= 1'b0;
      o_last     <= 1'b0;
      pend_instr <= 32'h0;
    end else if (accept) begin
      o_instr    <= word_a;
      o_err      <= err_a;
      o_last     <= !split;
      pend_instr <= word_b;
    end else if (pend_move) begin
      o_instr    <= pend_instr;
      o_err      <= 1'b0;
      o_last     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cg_rvarch_instr_encoder.sv
// tb/tb_cg_rvarch_instr_encoder.sv - scoreboard bench for cg_rvarch_instr_encoder
module tb_cg_rvarch_instr_encoder;

  logic        i_clk;
  logic        i_rst_n;
  logic        i_valid;
  logic        o_ready;
  logic [2:0]  i_fmt;
  logic [6:0]  i_opcode;
  logic [4:0]  i_rd;
  logic [4:0]  i_rs1;
  logic [4:0]  i_rs2;
  logic [2:0]  i_funct3;
  logic [6:0]  i_funct7;
  logic [31:0] i_imm;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_instr;
  logic        o_err;
  logic        o_last;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    logic        last;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_errors = 0;
  logic rnd_rdy  = 1'b0;

  cg_rvarch_instr_encoder #(.INSTR_WIDTH(32)) dut (
    .i_clk    (i_clk),
    .i_rst_n  (i_rst_n),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_fmt    (i_fmt),
    .i_opcode (i_opcode),
    .i_rd     (i_rd),
    .i_rs1    (i_rs1),
    .i_rs2    (i_rs2),
    .i_funct3 (i_funct3),
    .i_funct7 (i_funct7),
    .i_imm    (i_imm),
    .o_valid  (o_valid),
    .i_ready  (i_ready),
    .o_instr  (o_instr),
    .o_err    (o_err),
    .o_last   (o_last)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Compare each word on the cycle it is consumed
  always @(negedge i_clk) begin
    exp_t e;
    if (i_rst_n && o_valid && i_ready) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_word", o_instr, 32'hxxxx_xxxx);
      end else begin
        e = sb.pop_front();
        check("sb_instr", o_instr, e.instr);
        check("sb_err", {31'd0, o_err}, {31'd0, e.err});
        check("sb_last", {31'd0, o_last}, {31'd0, e.last});
      end
    end
  end

  // Random downstream stalls during the random phase
  always @(posedge i_clk) begin
    if (rnd_rdy) begin
      #1 i_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input logic [2:0] fmt, input logic [6:0] op, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] imm,
                      input logic [31:0] x0, input logic e0, input logic l0,
                      input logic two, input logic [31:0] x1);
    int   n;
    exp_t e;
    @(posedge i_clk);
    #1;
    i_fmt = fmt; i_opcode = op; i_rd = rd; i_rs1 = rs1; i_rs2 = rs2;
    i_funct3 = f3; i_funct7 = f7; i_imm = imm; i_valid = 1'b1;
    n = 0;
    while (1) begin
      @(negedge i_clk);
      if (o_ready) begin
        e.instr = x0; e.err = e0; e.last = l0;
        sb.push_back(e);
        if (two) begin
          e.instr = x1; e.err = 1'b0; e.last = 1'b1;
          sb.push_back(e);
        end
        break;
      end
      n++;
      if (n > 50) begin
        check("accept_timeout", 32'd0, 32'd1);
        break;
      end
    end
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
  endtask

  initial begin
    int          n;
    logic [31:0] imm;
    logic [6:0]  op;
    logic [4:0]  rd, rs1;
    logic [2:0]  f3;
    logic [31:0] x;
    logic        err;

    i_rst_n = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_fmt = '0; i_opcode = '0; i_rd = '0; i_rs1 = '0; i_rs2 = '0;
    i_funct3 = '0; i_funct7 = '0; i_imm = '0;
    repeat (2) @(negedge i_clk);
    check("rst_valid", {31'd0, o_valid}, 32'd0);
    check("rst_ready", {31'd0, o_ready}, 32'd1);
    check("rst_instr", o_instr, 32'h0);
    check("rst_err", {31'd0, o_err}, 32'd0);
    check("rst_last", {31'd0, o_last}, 32'd0);
    i_rst_n = 1'b1;

    // Directed encodings, downstream always ready
    send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0, 32'h002081B3, 1'b0, 1'b1, 1'b0, 32'h0);
    check("latency_valid", {31'd0, o_valid}, 32'd1);
    check("latency_instr", o_instr, 32'h002081B3);
    send(3'd1, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 32'hFFF00293, 1'b0, 1'b1, 1'b0, 32'h0);
    send(3'd1, 7'h13, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000800, 32'h80000293, 1'b1, 1'b1, 1'b0, 32'h0);
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h00000008, 32'h00208463, 1'b0, 1'b1, 1'b0, 32'h0);
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'h00000003, 32'h00208163, 1'b1, 1'b1, 1'b0, 32'h0);
    send(3'd2, 7'h23, 5'd0, 5'd2, 5'd5, 3'd2, 7'd0, 32'hFFFFFFFC, 32'hFE512E23, 1'b0, 1'b1, 1'b0, 32'h0);
    send(3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE000, 32'hABCDE0B7, 1'b0, 1'b1, 1'b0, 32'h0);
    send(3'd4, 7'h37, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000123, 32'h000000B7, 1'b1, 1'b1, 1'b0, 32'h0);
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00000008, 32'h008000EF, 1'b0, 1'b1, 1'b0, 32'h0);
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFE, 32'hFFFFF0EF, 1'b0, 1'b1, 1'b0, 32'h0);
    send(3'd7, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0, 32'h00000000, 1'b1, 1'b1, 1'b0, 32'h0);
    send(3'd0, 7'h30, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0, 32'h002081B0, 1'b1, 1'b1, 1'b0, 32'h0);
    send(3'd6, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF, 32'h12346537, 1'b0, 1'b0, 1'b1, 32'hFFF50513);
    send(3'd6, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h000007FF, 32'h7FF00513, 1'b0, 1'b1, 1'b0, 32'h0);
    send(3'd6, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h00001000, 32'h00001537, 1'b0, 1'b1, 1'b0, 32'h0);
    send(3'd6, 7'h01, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFFFFFF, 32'hFFF00513, 1'b0, 1'b1, 1'b0, 32'h0);

    // Backpressure across a split LI with a queued R request
    @(posedge i_clk); #1 i_ready = 1'b0;
    send(3'd6, 7'h00, 5'd10, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF, 32'h12346537, 1'b0, 1'b0, 1'b1, 32'hFFF50513);
    fork
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge i_clk);
          check("bp_lui_stable", o_instr, 32'h12346537);
          check("bp_lui_last", {31'd0, o_last}, 32'd0);
          check("bp_ready_low", {31'd0, o_ready}, 32'd0);
        end
        @(posedge i_clk); #1 i_ready = 1'b1;
        @(negedge i_clk);
        check("bp_ready_lui_consume", {31'd0, o_ready}, 32'd0);
        @(negedge i_clk);
        check("bp_addi_word", o_instr, 32'hFFF50513);
        check("bp_ready_addi_consume", {31'd0, o_ready}, 32'd1);
      end
      begin
        send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0, 32'h002081B3, 1'b0, 1'b1, 1'b0, 32'h0);
      end
    join
    check("bp_r_after_addi", o_instr, 32'h002081B3);

    // Random I-type traffic with random stalls
    rnd_rdy = 1'b1;
    for (int t = 0; t < 30; t++) begin
      case ($urandom_range(0, 3))
        0: imm = 32'($urandom_range(0, 2047));
        1: imm = -32'($urandom_range(1, 2048));
        2: imm = 32'h800 + 32'($urandom_range(0, 4000));
        default: imm = $urandom;
      endcase
      op  = ($urandom_range(0, 4) == 0) ? 7'h10 : 7'h13;
      rd  = 5'($urandom); rs1 = 5'($urandom); f3 = 3'($urandom);
      x   = {imm[11:0], rs1, f3, rd, op};
      err = (op[1:0] != 2'b11) || !(($signed(imm) >= -2048) && ($signed(imm) <= 2047));
      send(3'd1, op, rd, rs1, 5'd0, f3, 7'd0, imm, x, err, 1'b1, 1'b0, 32'h0);
    end
    rnd_rdy = 1'b0;
    @(posedge i_clk); #1 i_ready = 1'b1;
    n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(negedge i_clk);
      n++;
    end
    @(negedge i_clk);
    check("drain_empty", 32'(sb.size()), 32'd0);

    // Reset while an ADDI is pending
    @(posedge i_clk); #1 i_ready = 1'b0;
    send(3'd6, 7'h00, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345FFF, 32'h123463B7, 1'b0, 1'b0, 1'b1, 32'hFFF38393);
    @(negedge i_clk);
    check("pend_held", o_instr, 32'h123463B7);
    check("pend_ready", {31'd0, o_ready}, 32'd0);
    #2 i_rst_n = 1'b0;
    #1;
    check("arst_valid", {31'd0, o_valid}, 32'd0);
    check("arst_ready", {31'd0, o_ready}, 32'd1);
    check("arst_instr", o_instr, 32'h0);
    check("arst_last", {31'd0, o_last}, 32'd0);
    sb.delete();
    i_ready = 1'b1;
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge i_clk);
      check("post_rst_no_addi", {31'd0, o_valid}, 32'd0);
    end
    check("post_rst_ready", {31'd0, o_ready}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
